// File: rtl/apb_master_sequencer_pkg.sv
// Shared APB types: request/response bundles, sequencer state, sizing constants.
// Imported by the sequencer and any block that speaks to it.
package apb_master_sequencer_pkg;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESPOND
  } state_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        penable;
    logic        psel;
    logic        pwrite;
    logic [31:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_sequencer.sv
// APB master: one command in, one SETUP/ACCESS transfer out, one response back.
// Ports: clk/reset, cmd_* handshake, rsp_* handshake, apb_request__*/apb_response__*.
module apb_master_sequencer
  import apb_master_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] apb_request__paddr,
  output logic        apb_request__penable,
  output logic        apb_request__psel,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__pwdata,
  input  logic [31:0] apb_response__prdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      paddr_q;
  logic             pwrite_q;
  logic [31:0]      pwdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             to_q;
  apb_req_t         req;
  apb_rsp_t         rsp;

  assign rsp = '{
    prdata: apb_response__prdata,
    pready: apb_response__pready,
    perr:   apb_response__perr
  };

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (cmd_valid) state_n = ST_SETUP;
      ST_SETUP:   state_n = ST_ACCESS;
      ST_ACCESS:
        if (rsp.pready || cnt == TO_LIM)
          state_n = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Strobes decode only the state register, so no input
  // reaches an output without passing a flop.
  always_comb begin
    req         = '0;
    req.paddr   = paddr_q;
    req.pwrite  = pwrite_q;
    req.pwdata  = pwdata_q;
    req.psel    = (state == ST_SETUP) ||
                  (state == ST_ACCESS);
    req.penable = (state == ST_ACCESS);
    cmd_ready   = (state == ST_IDLE);
    rsp_valid   = (state == ST_RESPOND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
          end
        end
        ST_SETUP: cnt <= CNT_W'(1);
        ST_ACCESS: begin
          // pready wins even on the last allowed cycle
          if (rsp.pready) begin
            rdata_q <= pwrite_q ? '0 : rsp.prdata;
            err_q   <= rsp.perr;
            to_q    <= 1'b0;
          end else if (cnt == TO_LIM) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESPOND: cnt <= '0;
        default:    cnt <= '0;
      endcase
    end
  end

  assign apb_request__paddr   = req.paddr;
  assign apb_request__penable = req.penable;
  assign apb_request__psel    = req.psel;
  assign apb_request__pwrite  = req.pwrite;
  assign apb_request__pwdata  = req.pwdata;
  assign rsp_rdata            = rdata_q;
  assign rsp_err              = err_q;
  assign rsp_timeout          = to_q;

endmodule
